// File: rtl/dataslot_read_arbiter.sv
// Round-robin arbiter sharing the bridge_core dataslot read command channel between in-core requesters.
// Optional response watchdog enabled by defining DATASLOT_ARB_TIMEOUT_EN.
module dataslot_read_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd74_250_000
) (
    input  logic                    clk_74a,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*16-1:0]   req_slot_id,
    input  logic [NUM_REQ*32-1:0]   req_offset,
    input  logic [NUM_REQ*32-1:0]   req_bridge_addr,
    input  logic [NUM_REQ*32-1:0]   req_length,
    output logic [NUM_REQ-1:0]      done_valid,
    output logic [7:0]              done_status,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [15:0]             cmd_slot_id,
    output logic [31:0]             cmd_offset,
    output logic [31:0]             cmd_bridge_addr,
    output logic [31:0]             cmd_length,
    input  logic                    rsp_valid,
    input  logic [7:0]              rsp_status,
    output logic                    busy,
    output logic [2:0]              grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  last_grant;
    logic [2:0]  grant_q;
    logic [2:0]  pick;
    logic        pick_found;
    logic        accept;
    logic        timeout_hit;
    logic [7:0]  status_q;
    logic [15:0] sel_slot;
    logic [31:0] sel_offset;
    logic [31:0] sel_addr;
    logic [31:0] sel_length;

    // Rotating priority: the requester just after the previous winner is searched first.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_found && req_valid[i] && ((int'(last_grant) + off) % NUM_REQ == i)) begin
                    pick       = 3'(i);
                    pick_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_slot   = '0;
        sel_offset = '0;
        sel_addr   = '0;
        sel_length = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == 3'(i)) begin
                sel_slot   = req_slot_id[i*16 +: 16];
                sel_offset = req_offset[i*32 +: 32];
                sel_addr   = req_bridge_addr[i*32 +: 32];
                sel_length = req_length[i*32 +: 32];
            end
        end
    end

    assign accept = (state == ST_IDLE) && pick_found;

    always_comb begin
        req_ready  = '0;
        done_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i]  = accept && (pick == 3'(i));
            done_valid[i] = (state == ST_DONE) && (grant_q == 3'(i));
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Zero-length requests skip the bridge entirely and complete with status 0.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = (sel_length == 32'd0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (cmd_ready) state_next = ST_WAIT;
            ST_WAIT:  if (rsp_valid || timeout_hit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            cmd_slot_id     <= '0;
            cmd_offset      <= '0;
            cmd_bridge_addr <= '0;
            cmd_length      <= '0;
            grant_q         <= '0;
            last_grant      <= 3'(NUM_REQ - 1);
            status_q        <= '0;
        end else begin
            if (accept) begin
                cmd_slot_id     <= sel_slot;
                cmd_offset      <= sel_offset;
                cmd_bridge_addr <= sel_addr;
                cmd_length      <= sel_length;
                grant_q         <= pick;
                last_grant      <= pick;
                status_q        <= 8'h00;
            end else if (state == ST_WAIT) begin
                // A real response arriving on the expiry cycle takes precedence.
                if (rsp_valid) begin
                    status_q <= rsp_status;
                end else if (timeout_hit) begin
                    status_q <= 8'hFF;
                end
            end
        end
    end

`ifdef DATASLOT_ARB_TIMEOUT_EN
    logic [31:0] wait_cnt;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE && cmd_ready) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == TIMEOUT_CYCLES - 32'd1);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    assign cmd_valid   = (state == ST_ISSUE);
    assign busy        = (state != ST_IDLE);
    assign grant_id    = grant_q;
    assign done_status = (state == ST_DONE) ? status_q : 8'h00;

endmodule

// File: tb/tb_dataslot_read_arbiter.sv
// Self-checking bench for dataslot_read_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model. Define DATASLOT_ARB_TIMEOUT_EN to test the watchdog.
module tb_dataslot_read_arbiter;

    localparam int NUM_REQ = 2;
`ifdef DATASLOT_ARB_TIMEOUT_EN
    localparam logic [31:0] TMO = 32'd16;
`else
    localparam logic [31:0] TMO = 32'd74_250_000;
`endif

    logic                  clk_74a = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_slot_id = '0;
    logic [NUM_REQ*32-1:0] req_offset = '0;
    logic [NUM_REQ*32-1:0] req_bridge_addr = '0;
    logic [NUM_REQ*32-1:0] req_length = '0;
    logic [NUM_REQ-1:0]    done_valid;
    logic [7:0]            done_status;
    logic                  cmd_valid;
    logic                  cmd_ready = 1'b0;
    logic [15:0]           cmd_slot_id;
    logic [31:0]           cmd_offset;
    logic [31:0]           cmd_bridge_addr;
    logic [31:0]           cmd_length;
    logic                  rsp_valid = 1'b0;
    logic [7:0]            rsp_status = '0;
    logic                  busy;
    logic [2:0]            grant_id;

    int errors = 0;
    int checks = 0;

    logic [15:0]        m_slot [NUM_REQ];
    logic [31:0]        m_off  [NUM_REQ];
    logic [31:0]        m_addr [NUM_REQ];
    logic [31:0]        m_len  [NUM_REQ];
    logic [NUM_REQ-1:0] pend = '0;
    int                 model_last;

    dataslot_read_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_74a         (clk_74a),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_slot_id     (req_slot_id),
        .req_offset      (req_offset),
        .req_bridge_addr (req_bridge_addr),
        .req_length      (req_length),
        .done_valid      (done_valid),
        .done_status     (done_status),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_slot_id     (cmd_slot_id),
        .cmd_offset      (cmd_offset),
        .cmd_bridge_addr (cmd_bridge_addr),
        .cmd_length      (cmd_length),
        .rsp_valid       (rsp_valid),
        .rsp_status      (rsp_status),
        .busy            (busy),
        .grant_id        (grant_id)
    );

    always #5 clk_74a = ~clk_74a;

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout simulation did not finish within bound");
        $fatal(1, "[TB] global timeout");
    end

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_slot_id[i*16 +: 16]     = m_slot[i];
            req_offset[i*32 +: 32]      = m_off[i];
            req_bridge_addr[i*32 +: 32] = m_addr[i];
            req_length[i*32 +: 32]      = m_len[i];
        end
        req_valid = pend;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            m_slot[i] = '0; m_off[i] = '0; m_addr[i] = '0; m_len[i] = '0;
        end
        pend = '0;
        drive_reqs();
        reset_n = 1'b0;
        repeat (3) @(negedge clk_74a);
        checks++;
        if ({req_ready, done_valid, done_status, cmd_valid, busy, grant_id} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got=%h exp=0", {req_ready, done_valid, done_status, cmd_valid, busy, grant_id});
        end
        checks++;
        if ({cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_cmd got=%h exp=0", {cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length});
        end
        reset_n = 1'b1;
        model_last = NUM_REQ - 1;
        @(negedge clk_74a);
        checks++;
        if ({req_ready, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL idle_no_req got=%b exp=0", {req_ready, busy});
        end
    endtask

    task automatic test_single();
        logic [112:0] exp_cmd;
        int n_cmd = 0;
        int n_done = 0;
        m_slot[0] = 16'h0001; m_off[0] = 32'h0; m_addr[0] = 32'h0; m_len[0] = 32'h100;
        pend = 2'b01;
        drive_reqs();
        cmd_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL single_ready got=%b exp=01", req_ready);
        end
        @(negedge clk_74a);
        pend = '0;
        drive_reqs();
        exp_cmd = {1'b1, 16'h0001, 32'h0, 32'h0, 32'h100};
        checks++;
        if ({cmd_valid, cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length} !== exp_cmd) begin
            errors++;
            $display("[TB] FAIL single_cmd got=%h exp=%h", {cmd_valid, cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length}, exp_cmd);
        end
        n_cmd = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_74a);
            cmd_ready = 1'b0;
            if (cmd_valid) n_cmd++;
            if (done_valid != '0) n_done++;
        end
        rsp_valid  = 1'b1;
        rsp_status = 8'h01;
        @(negedge clk_74a);
        checks++;
        if ({done_valid, done_status} !== {2'b01, 8'h01}) begin
            errors++;
            $display("[TB] FAIL single_done got=%b/%h exp=01/01", done_valid, done_status);
        end
        rsp_valid = 1'b0;
        checks++;
        if (n_cmd != 1 || n_done != 0) begin
            errors++;
            $display("[TB] FAIL single_counts got cmd=%0d done_early=%0d exp cmd=1 done_early=0", n_cmd, n_done);
        end
        model_last = 0;
        @(negedge clk_74a);
        checks++;
        if ({busy, done_valid} !== '0) begin
            errors++;
            $display("[TB] FAIL single_idle got=%b exp=0", {busy, done_valid});
        end
    endtask

    task automatic test_contention();
        int ndone = 0;
        int last_cyc = 0;
        int exp_w;
        logic [NUM_REQ-1:0] exp_oh;
        reset_n = 1'b0;
        m_slot[0] = 16'hA000; m_off[0] = 32'h10; m_addr[0] = 32'h1000; m_len[0] = 32'h10;
        m_slot[1] = 16'hB000; m_off[1] = 32'h20; m_addr[1] = 32'h2000; m_len[1] = 32'h20;
        pend = '1;
        drive_reqs();
        cmd_ready  = 1'b1;
        rsp_valid  = 1'b1;
        rsp_status = 8'h5A;
        model_last = NUM_REQ - 1;
        @(negedge clk_74a);
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
            @(negedge clk_74a);
            checks++;
            if ($countones(req_ready) > 1) begin
                errors++;
                $display("[TB] FAIL contention_onehot got=%b exp=at most one bit", req_ready);
            end
            if (done_valid != '0) begin
                exp_w  = (model_last + 1) % NUM_REQ;
                exp_oh = NUM_REQ'(1) << exp_w;
                checks++;
                if ({done_valid, done_status} !== {exp_oh, 8'h5A}) begin
                    errors++;
                    $display("[TB] FAIL contention_order got=%b/%h exp=%b/5a", done_valid, done_status, exp_oh);
                end
                if (ndone > 0) begin
                    checks++;
                    if (cyc - last_cyc != 4) begin
                        errors++;
                        $display("[TB] FAIL contention_turnaround got=%0d exp=4", cyc - last_cyc);
                    end
                end
                model_last = exp_w;
                last_cyc   = cyc;
                ndone++;
            end
        end
        checks++;
        if (ndone != 4) begin
            errors++;
            $display("[TB] FAIL contention_count got=%0d exp=4", ndone);
        end
        pend = '0;
        drive_reqs();
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        @(negedge clk_74a);
    endtask

    task automatic test_backpressure();
        logic [112:0] exp_cmd;
        m_slot[0] = 16'($urandom); m_off[0] = $urandom; m_addr[0] = $urandom; m_len[0] = $urandom | 32'h1;
        pend = 2'b01;
        drive_reqs();
        cmd_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bp_ready got=%b exp=01", req_ready);
        end
        @(negedge clk_74a);
        pend = '0;
        drive_reqs();
        exp_cmd = {1'b1, m_slot[0], m_off[0], m_addr[0], m_len[0]};
        rsp_status = 8'h77;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk_74a);
            checks++;
            if ({cmd_valid, cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length, done_valid} !== {exp_cmd, 2'b00}) begin
                errors++;
                $display("[TB] FAIL bp_hold cyc=%0d got=%h/%b exp=%h/00", i, {cmd_valid, cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length}, done_valid, exp_cmd);
            end
            rsp_valid = (i == 5);
        end
        rsp_valid = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk_74a);
        checks++;
        if ({cmd_valid, busy, done_valid} !== {1'b0, 1'b1, 2'b00}) begin
            errors++;
            $display("[TB] FAIL bp_wait got=%b exp=0100", {cmd_valid, busy, done_valid});
        end
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b1;
        rsp_status = 8'h33;
        @(negedge clk_74a);
        checks++;
        if ({done_valid, done_status} !== {2'b01, 8'h33}) begin
            errors++;
            $display("[TB] FAIL bp_done got=%b/%h exp=01/33", done_valid, done_status);
        end
        rsp_valid  = 1'b0;
        model_last = 0;
        @(negedge clk_74a);
    endtask

    task automatic test_zero_len();
        m_slot[1] = 16'h0042; m_off[1] = 32'h80; m_addr[1] = 32'h3000; m_len[1] = 32'h0;
        pend = 2'b10;
        drive_reqs();
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("[TB] FAIL zero_ready got=%b exp=10", req_ready);
        end
        @(negedge clk_74a);
        pend = '0;
        drive_reqs();
        checks++;
        if ({done_valid, done_status, cmd_valid, busy} !== {2'b10, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL zero_done got=%b/%h/%b/%b exp=10/00/0/1", done_valid, done_status, cmd_valid, busy);
        end
        model_last = 1;
        @(negedge clk_74a);
        checks++;
        if ({busy, cmd_valid, done_valid} !== '0) begin
            errors++;
            $display("[TB] FAIL zero_idle got=%b exp=0", {busy, cmd_valid, done_valid});
        end
    endtask

    task automatic test_reset_wait();
        m_slot[0] = 16'h0005; m_off[0] = 32'h4; m_addr[0] = 32'h4000; m_len[0] = 32'h40;
        m_slot[1] = 16'h0006; m_off[1] = 32'h8; m_addr[1] = 32'h5000; m_len[1] = 32'h80;
        pend = 2'b01;
        drive_reqs();
        cmd_ready = 1'b1;
        @(negedge clk_74a);
        pend = '0;
        drive_reqs();
        @(negedge clk_74a);
        cmd_ready = 1'b0;
        checks++;
        if ({busy, cmd_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rstw_inwait got=%b exp=10", {busy, cmd_valid});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, done_valid, done_status, cmd_valid, busy, grant_id, cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length} !== '0) begin
            errors++;
            $display("[TB] FAIL rstw_async got=%h exp=0", {req_ready, done_valid, done_status, cmd_valid, busy, grant_id, cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length});
        end
        rsp_valid  = 1'b1;
        rsp_status = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_74a);
            checks++;
            if (done_valid !== '0) begin
                errors++;
                $display("[TB] FAIL rstw_nodone got=%b exp=00", done_valid);
            end
        end
        rsp_valid = 1'b0;
        reset_n = 1'b1;
        model_last = NUM_REQ - 1;
        pend = 2'b11;
        drive_reqs();
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rstw_regrant got=%b exp=01", req_ready);
        end
        @(negedge clk_74a);
        pend = '0;
        drive_reqs();
        cmd_ready = 1'b1;
        @(negedge clk_74a);
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b1;
        rsp_status = 8'h11;
        @(negedge clk_74a);
        checks++;
        if ({done_valid, done_status} !== {2'b01, 8'h11}) begin
            errors++;
            $display("[TB] FAIL rstw_done got=%b/%h exp=01/11", done_valid, done_status);
        end
        rsp_valid  = 1'b0;
        model_last = 0;
        @(negedge clk_74a);
    endtask

    task automatic test_random();
        int w;
        int c;
        int d;
        int r;
        logic [7:0] s;
        logic [NUM_REQ-1:0] exp_oh;
        logic [112:0] exp_cmd;
        reset_n = 1'b0;
        pend = '0;
        drive_reqs();
        @(negedge clk_74a);
        reset_n = 1'b1;
        model_last = NUM_REQ - 1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    m_slot[i] = 16'($urandom); m_off[i] = $urandom; m_addr[i] = $urandom;
                    m_len[i]  = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1);
                    pend[i]   = 1'b1;
                end
            end
            if (pend == '0) begin
                c = $urandom_range(0, NUM_REQ - 1);
                m_slot[c] = 16'($urandom); m_off[c] = $urandom; m_addr[c] = $urandom;
                m_len[c]  = $urandom | 32'h1;
                pend[c]   = 1'b1;
            end
            drive_reqs();
            w = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (model_last + k) % NUM_REQ;
                if (w < 0 && pend[c]) w = c;
            end
            exp_oh  = NUM_REQ'(1) << w;
            exp_cmd = {1'b1, m_slot[w], m_off[w], m_addr[w], m_len[w]};
            #1;
            checks++;
            if (req_ready !== exp_oh) begin
                errors++;
                $display("[TB] FAIL rand_ready t=%0d got=%b exp=%b", t, req_ready, exp_oh);
            end
            @(negedge clk_74a);
            pend[w] = 1'b0;
            drive_reqs();
            model_last = w;
            if (m_len[w] == 32'h0) begin
                checks++;
                if ({done_valid, done_status, cmd_valid} !== {exp_oh, 8'h00, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL rand_zero t=%0d got=%b/%h/%b exp=%b/00/0", t, done_valid, done_status, cmd_valid, exp_oh);
                end
            end else begin
                checks++;
                if ({cmd_valid, cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length, req_ready, grant_id} !== {exp_cmd, {NUM_REQ{1'b0}}, 3'(w)}) begin
                    errors++;
                    $display("[TB] FAIL rand_cmd t=%0d got=%h/%b/%0d exp=%h/0/%0d", t, {cmd_valid, cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length}, req_ready, grant_id, exp_cmd, w);
                end
                d = $urandom_range(0, 3);
                for (int i = 0; i < d; i++) begin
                    @(negedge clk_74a);
                    checks++;
                    if ({cmd_valid, cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length} !== exp_cmd) begin
                        errors++;
                        $display("[TB] FAIL rand_stall t=%0d got=%h exp=%h", t, {cmd_valid, cmd_slot_id, cmd_offset, cmd_bridge_addr, cmd_length}, exp_cmd);
                    end
                end
                cmd_ready = 1'b1;
                @(negedge clk_74a);
                cmd_ready = 1'b0;
                checks++;
                if ({cmd_valid, busy, done_valid} !== {1'b0, 1'b1, {NUM_REQ{1'b0}}}) begin
                    errors++;
                    $display("[TB] FAIL rand_wait t=%0d got=%b exp=0100", t, {cmd_valid, busy, done_valid});
                end
                r = $urandom_range(0, 3);
                for (int i = 0; i < r; i++) begin
                    @(negedge clk_74a);
                    checks++;
                    if (done_valid !== '0) begin
                        errors++;
                        $display("[TB] FAIL rand_early_done t=%0d got=%b exp=00", t, done_valid);
                    end
                end
                s = 8'($urandom);
                rsp_valid  = 1'b1;
                rsp_status = s;
                @(negedge clk_74a);
                rsp_valid = 1'b0;
                checks++;
                if ({done_valid, done_status} !== {exp_oh, s}) begin
                    errors++;
                    $display("[TB] FAIL rand_done t=%0d got=%b/%h exp=%b/%h", t, done_valid, done_status, exp_oh, s);
                end
            end
            @(negedge clk_74a);
        end
        pend = '0;
        drive_reqs();
        @(negedge clk_74a);
    endtask

`ifdef DATASLOT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int got = 0;
        logic [7:0] st = '0;
        m_slot[0] = 16'h0009; m_off[0] = 32'h0; m_addr[0] = 32'h6000; m_len[0] = 32'h8;
        pend = 2'b01;
        drive_reqs();
        cmd_ready = 1'b1;
        rsp_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL tmo_ready got=%b exp=01", req_ready);
        end
        @(negedge clk_74a);
        pend = '0;
        drive_reqs();
        for (int k = 1; k <= 40 && got == 0; k++) begin
            @(negedge clk_74a);
            if (k == 1) cmd_ready = 1'b0;
            if (done_valid != '0) begin
                got = k;
                st  = done_status;
            end
        end
        checks++;
        if (got != 17) begin
            errors++;
            $display("[TB] FAIL tmo_latency got=%0d exp=17 (16 WAIT cycles)", got);
        end
        checks++;
        if (st !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL tmo_status got=%h exp=ff", st);
        end
        @(negedge clk_74a);
    endtask
`endif

    initial begin
        $display("[TB] starting dataslot_read_arbiter bench");
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_zero_len();
        test_reset_wait();
        test_random();
`ifdef DATASLOT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dataslot_read_arbiter.md
# dataslot_read_arbiter

Shares the single `core_dataslot_read` command channel of `bridge_core` between several in-core requesters (ROM loader, save loader, asset streamer). It accepts one request at a time per requester, grants them round-robin, issues exactly one command to the bridge, waits for the host response, and returns the completion status to the winning requester. It sits between `jailbreak_core` sub-blocks and the `bridge_core` command interface, in the `clk_74a` domain.

## Interface
- `NUM_REQ`, default 2: number of requesters, 1..8.
- `TIMEOUT_CYCLES`, default 32'd74_250_000: response watchdog in clocks; used only with the timeout feature.

Ports:
- `clk_74a`  in  1  sole clock (74.25 MHz bridge domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request strobe; held until accepted.
- `req_ready`  out  NUM_REQ  accept; at most one bit set.
- `req_slot_id`  in  NUM_REQ×16  dataslot id.
- `req_offset`  in  NUM_REQ×32  byte offset in slot.
- `req_bridge_addr`  in  NUM_REQ×32  target bridge address.
- `req_length`  in  NUM_REQ×32  byte count.
- `done_valid`  out  NUM_REQ  one-cycle completion pulse to owning requester.
- `done_status`  out  8  completion status, valid with `done_valid`.
- `cmd_valid`  out  1  command to bridge_core.
- `cmd_ready`  in  1  bridge_core accepted command.
- `cmd_slot_id`, `cmd_offset`, `cmd_bridge_addr`, `cmd_length`  out  16/32/32/32  captured fields.
- `rsp_valid`  in  1  host response pulse.
- `rsp_status`  in  8  host status code.
- `busy`  out  1  high in any state except IDLE.
- `grant_id`  out  3  index of current owner; valid while `busy`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: combinational round-robin pick among `req_valid`, search starting at `last_grant+1` modulo NUM_REQ; `req_ready[winner]=1`. On handshake: capture fields into `cmd_*`, `grant_id<=winner`, `last_grant<=winner`; if `req_length==0` go DONE with status 8'h00 (no command issued), else go ISSUE.
- ISSUE: `cmd_valid=1`, fields stable; on `cmd_ready` go WAIT. `rsp_valid` in ISSUE is ignored.
- WAIT: on `rsp_valid` capture `rsp_status`, go DONE.
- DONE: `done_valid[grant_id]=1`, `done_status` = captured status, for exactly one cycle; go IDLE.
- `req_ready` is zero outside IDLE; requests arriving while busy wait.
- A requester withdrawing `req_valid` before acceptance is legal; it is simply not granted.
- Reset mid-transaction: all state dropped, no `done_valid` issued; requester must re-request.

## Timing
- Reset values: `req_ready=0` (combinational, follows state IDLE with no request), `done_valid=0`, `done_status=0`, `cmd_valid=0`, `cmd_*=0`, `busy=0`, `grant_id=0`, `last_grant=NUM_REQ-1` (requester 0 wins first).
- Accept → `cmd_valid` high: 1 cycle. `cmd_ready` → WAIT next edge. `rsp_valid` → `done_valid` next cycle. DONE → IDLE: 1 cycle, so next accept no earlier than 1 cycle after `done_valid`.
- Minimum turnaround per request (cmd_ready and rsp_valid immediate): 4 cycles.
- Zero-length request: `done_valid` 1 cycle after accept.
- `cmd_valid` never drops before `cmd_ready`; `cmd_*` never change while `cmd_valid=1`.

## Configuration
- `DATASLOT_ARB_TIMEOUT_EN` defined: 32-bit counter clears on entry to WAIT, increments each WAIT cycle; reaching `TIMEOUT_CYCLES` without `rsp_valid` forces DONE with status 8'hFF. `rsp_valid` on the same cycle as expiry wins (real status reported).
- Not defined: no counter; WAIT is held indefinitely until `rsp_valid`.

## Test plan
- Single request: req 0 slot 16'h0001, offset 0, addr 32'h0000_0000, len 32'h100; cmd_ready same cycle, rsp_status 8'h01 after 10 cycles → one `cmd_valid` with those fields, `done_valid=2'b01`, `done_status=8'h01`.
- Contention: req 0 and req 1 both valid and held from reset → grants in order 0,1,0,1 across four completions; `req_ready` never has two bits set.
- Backpressure: `cmd_ready` held low 20 cycles → `cmd_valid` stays high, `cmd_*` constant, `rsp_valid` pulsed during ISSUE ignored (no done).
- Zero length: req 1 with len 0 → `done_valid=2'b10`, status 8'h00, `cmd_valid` never asserted.
- Reset during WAIT: assert `reset_n=0` asynchronously → all outputs at reset values immediately, no `done_valid`; next request granted to req 0.
- With `DATASLOT_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`, no response → `done_status=8'hFF` exactly 16 WAIT cycles after `cmd_ready`.
